// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard/forwarding controller.
//   fwd_sel_e  : forward-mux select encoding for one operand port.
//   hz_state_e : controller FSM state (RUN / MC_WAIT).
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand from register file
    FWD_WB  = 2'b01,  // operand from WB-stage result
    FWD_MEM = 2'b10   // operand from MEM-stage ALU result
  } fwd_sel_e;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_sel_unit.sv
// fwd_sel_unit: forward-select decision for a single EX source-operand port.
// Ports:
//   ex_rs        in  REG_AW  source register read by the EX instruction
//   mem_rd       in  REG_AW  destination of the MEM instruction
//   mem_regwrite in  1       MEM instruction writes mem_rd
//   wb_rd        in  REG_AW  destination of the WB instruction
//   wb_regwrite  in  1       WB instruction writes wb_rd
//   sel          out 2       fwd_sel_e encoding (MEM beats WB, x0 never forwarded)
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  // Register x0 is hard-wired zero, so a "write" to it must never be forwarded.
  assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
  assign wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);

  // MEM holds the younger result, so it takes priority over WB.
  always_comb begin
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: hazard/forwarding controller for a 5-stage pipeline.
// Generates forward-mux selects for NUM_RS operand ports, load-use stalls,
// taken-branch flushes, and a RUN/MC_WAIT FSM that freezes the front end while a
// variable-latency EX op runs, with a watchdog that aborts it after MC_TIMEOUT cycles.
// Ports:
//   clk, reset (sync, active-high)
//   id_rs/id_rs_used, ex_rs/ex_rd/ex_regwrite/ex_memread/ex_mc_start  ID/EX stage info
//   mc_done                          multi-cycle unit result ready (pulse)
//   mem_rd/mem_regwrite, wb_rd/wb_regwrite  producer info for forwarding
//   branch_taken                     taken branch resolved in MEM
//   fwd_sel                          per-port 2-bit forward select
//   pc_write, if_id_write, id_ex_write   stage write enables
//   id_ex_bubble, ex_mem_bubble      insert zeroed controls
//   flush_if_id, flush_id_ex, flush_ex_mem  squash stage registers
//   mc_abort (pulse), mc_timeout (sticky until reset)
// Optional macro HAZARD_PERF_EN adds perf_stall_cnt / perf_flush_cnt (CNT_W, saturating).
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_RS     = 2,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RS*REG_AW-1:0] id_rs,
  input  logic [NUM_RS-1:0]        id_rs_used,
  input  logic [NUM_RS*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]        ex_rd,
  input  logic                     ex_regwrite,
  input  logic                     ex_memread,
  input  logic                     ex_mc_start,
  input  logic                     mc_done,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic                     mem_regwrite,
  input  logic [REG_AW-1:0]        wb_rd,
  input  logic                     wb_regwrite,
  input  logic                     branch_taken,
  output logic [NUM_RS*2-1:0]      fwd_sel,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     id_ex_write,
  output logic                     id_ex_bubble,
  output logic                     ex_mem_bubble,
  output logic                     flush_if_id,
  output logic                     flush_id_ex,
  output logic                     flush_ex_mem,
  output logic                     mc_abort,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]         perf_stall_cnt,
  output logic [CNT_W-1:0]         perf_flush_cnt,
`endif
  output logic                     mc_timeout
);

  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

  if (MC_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("hazard_forward_ctrl: MC_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  // ex_regwrite is informational here: a load always writes rd, and forwarding
  // is keyed on the MEM/WB write enables, not the EX one.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  // ---------------- forwarding ----------------
  logic [NUM_RS*2-1:0] fwd_raw;

  for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_fwd
    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd (
      .ex_rs        (ex_rs[gi*REG_AW +: REG_AW]),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_raw[gi*2 +: 2])
    );
  end

  assign fwd_sel = reset ? '0 : fwd_raw;

  // ---------------- load-use detection ----------------
  logic [NUM_RS-1:0] lu_hit;
  logic              load_use;

  for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_lu
    assign lu_hit[gi] = id_rs_used[gi] && (id_rs[gi*REG_AW +: REG_AW] == ex_rd);
  end

  assign load_use = ex_memread && (ex_rd != '0) && (|lu_hit);

  // ---------------- control FSM ----------------
  hz_state_e       state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            mc_timeout_reg, mc_timeout_next;

  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    id_ex_write     = 1'b1;
    id_ex_bubble    = 1'b0;
    ex_mem_bubble   = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    flush_ex_mem    = 1'b0;
    mc_abort        = 1'b0;
    state_next      = state_reg;
    timer_next      = timer_reg;
    mc_timeout_next = mc_timeout_reg;

    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            // Wrong-path instructions are squashed; a multi-cycle op in EX is
            // on the wrong path too, so it is cancelled instead of started.
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            mc_abort     = ex_mc_start;
          end else begin
            if (load_use) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
            if (ex_mc_start) begin
              state_next = MC_WAIT;
              timer_next = '0;
            end
          end
        end
        MC_WAIT: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          timer_next    = timer_reg + 1'b1;
          if (mc_done) begin
            // Result ready: let the op and everything behind it advance.
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_bubble = 1'b0;
            state_next    = RUN;
          end else if (timer_reg == TIMER_LAST) begin
            mc_abort        = 1'b1;
            mc_timeout_next = 1'b1;
            flush_id_ex     = 1'b1;
            state_next      = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RUN;
      timer_reg      <= '0;
      mc_timeout_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      mc_timeout_reg <= mc_timeout_next;
    end
  end

  assign mc_timeout = mc_timeout_reg && !reset;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_write && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (branch_taken && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`endif

`ifndef SYNTHESIS
  // EX/MEM only holds bubbles while waiting, so no branch can resolve then.
  a_no_branch_in_wait: assert property (@(posedge clk) disable iff (reset)
    !(state_reg == MC_WAIT && branch_taken));
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed self-checking bench for hazard_forward_ctrl
// (MC_TIMEOUT=8). Inputs change 1 time unit after posedge; outputs are sampled
// at the following negedge.
module tb_hazard_forward_ctrl;

  localparam int REG_AW = 5;
  localparam int NUM_RS = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_RS*REG_AW-1:0] id_rs;
  logic [NUM_RS-1:0]        id_rs_used;
  logic [NUM_RS*REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0]        ex_rd;
  logic                     ex_regwrite, ex_memread, ex_mc_start, mc_done;
  logic [REG_AW-1:0]        mem_rd, wb_rd;
  logic                     mem_regwrite, wb_regwrite, branch_taken;
  logic [NUM_RS*2-1:0]      fwd_sel;
  logic pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
  logic flush_if_id, flush_id_ex, flush_ex_mem, mc_abort, mc_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(
    .REG_AW(REG_AW), .NUM_RS(NUM_RS), .MC_TIMEOUT(8), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .fwd_sel(fwd_sel), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .mc_abort(mc_abort),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .mc_timeout(mc_timeout)
  );

  task automatic clear_inputs();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0;
    ex_regwrite = 0; ex_memread = 0; ex_mc_start = 0; mc_done = 0;
    mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0; branch_taken = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1;
    ex_memread = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    next_cycle(); next_cycle();
    @(negedge clk);
    vectors++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL rst_fwd_sel got %b want 0000", fwd_sel); end
    vectors++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got %b want 1", pc_write); end
    vectors++; if (id_ex_bubble !== 1'b0) begin errors++; $display("FAIL rst_id_ex_bubble got %b want 0", id_ex_bubble); end
    vectors++; if (mc_timeout !== 1'b0) begin errors++; $display("FAIL rst_mc_timeout got %b want 0", mc_timeout); end
    next_cycle();
    clear_inputs();
    reset = 0;
    @(negedge clk);
    vectors++; if (ex_mem_bubble !== 1'b0) begin errors++; $display("FAIL rst_ex_mem_bubble got %b want 0", ex_mem_bubble); end
    $display("test_reset done");
    next_cycle();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1; wb_rd = 5'd5; wb_regwrite = 1;
    @(negedge clk);
    vectors++; if (fwd_sel[1:0] !== 2'b10) begin errors++; $display("FAIL fwd_mem_prio got %b want 10", fwd_sel[1:0]); end
    next_cycle();
    mem_regwrite = 0;
    @(negedge clk);
    vectors++; if (fwd_sel[1:0] !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b want 01", fwd_sel[1:0]); end
    next_cycle();
    // port1 reads x0 while MEM "writes" x0; port0 still forwards from WB
    mem_rd = 5'd0; mem_regwrite = 1;
    @(negedge clk);
    vectors++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_x0 got %b want 0001", fwd_sel); end
    next_cycle();
    ex_rs = {5'd9, 5'd3}; mem_rd = 5'd9; wb_rd = 5'd3;
    @(negedge clk);
    vectors++; if (fwd_sel !== 4'b1001) begin errors++; $display("FAIL fwd_both_ports got %b want 1001", fwd_sel); end
    next_cycle();
    wb_regwrite = 0;
    @(negedge clk);
    vectors++; if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL fwd_no_wb got %b want 1000", fwd_sel); end
    $display("test_forwarding done");
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd2}; id_rs_used = 2'b10;
    @(negedge clk);
    vectors++; if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write got %b want 0", pc_write); end
    vectors++; if (if_id_write !== 1'b0) begin errors++; $display("FAIL lu_if_id_write got %b want 0", if_id_write); end
    vectors++; if (id_ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got %b want 1", id_ex_bubble); end
    vectors++; if (id_ex_write !== 1'b1) begin errors++; $display("FAIL lu_id_ex_write got %b want 1", id_ex_write); end
    next_cycle();
    ex_memread = 0; ex_rd = 5'd0;  // load advanced, bubble now in EX
    @(negedge clk);
    vectors++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got %b want 1", pc_write); end
    next_cycle();
    ex_memread = 1; ex_rd = 5'd7; id_rs_used = 2'b00;
    @(negedge clk);
    vectors++; if (id_ex_bubble !== 1'b0) begin errors++; $display("FAIL lu_unused got %b want 0", id_ex_bubble); end
    next_cycle();
    ex_rd = 5'd0; id_rs = {5'd0, 5'd2}; id_rs_used = 2'b10;
    @(negedge clk);
    vectors++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_x0 got %b want 1", pc_write); end
    $display("test_load_use done");
    next_cycle();
  endtask

  task automatic test_multicycle();
    clear_inputs();
    ex_mc_start = 1;
    @(negedge clk);
    vectors++; if (pc_write !== 1'b1) begin errors++; $display("FAIL mc_start_cycle pc_write got %b want 1", pc_write); end
    next_cycle();
    // load-use pattern present while frozen must not raise id_ex_bubble
    ex_memread = 1; ex_rd = 5'd4; id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if ({pc_write, if_id_write, id_ex_write, ex_mem_bubble} !== 4'b0001) begin
        errors++; $display("FAIL mc_frozen[%0d] got {pc,ifid,idex,bub}=%b want 0001", k, {pc_write, if_id_write, id_ex_write, ex_mem_bubble});
      end
      vectors++; if (id_ex_bubble !== 1'b0) begin errors++; $display("FAIL mc_no_lu[%0d] got %b want 0", k, id_ex_bubble); end
      next_cycle();
    end
    ex_memread = 0; ex_rd = 5'd0; id_rs_used = 2'b00;
    mc_done = 1;
    @(negedge clk);
    vectors++; if ({pc_write, if_id_write, id_ex_write, ex_mem_bubble, mc_abort} !== 5'b11100) begin
      errors++; $display("FAIL mc_done got {pc,ifid,idex,bub,abort}=%b want 11100", {pc_write, if_id_write, id_ex_write, ex_mem_bubble, mc_abort});
    end
    next_cycle();
    mc_done = 0; ex_mc_start = 0;
    @(negedge clk);
    vectors++; if ({pc_write, ex_mem_bubble} !== 2'b10) begin errors++; $display("FAIL mc_back_run got %b want 10", {pc_write, ex_mem_bubble}); end
    $display("test_multicycle done");
    next_cycle();
  endtask

  task automatic test_timeout();
    clear_inputs();
    ex_mc_start = 1;
    next_cycle();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      vectors++; if ({mc_abort, pc_write} !== 2'b00) begin errors++; $display("FAIL to_wait[%0d] got {abort,pc}=%b want 00", k, {mc_abort, pc_write}); end
      next_cycle();
    end
    @(negedge clk);
    vectors++; if ({mc_abort, flush_id_ex, mc_timeout} !== 3'b110) begin
      errors++; $display("FAIL to_fire got {abort,flush_id_ex,timeout}=%b want 110", {mc_abort, flush_id_ex, mc_timeout});
    end
    ex_mc_start = 0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if ({mc_abort, mc_timeout, pc_write} !== 3'b011) begin
        errors++; $display("FAIL to_sticky[%0d] got {abort,timeout,pc}=%b want 011", k, {mc_abort, mc_timeout, pc_write});
      end
      next_cycle();
    end
    // mc_done arriving on the last allowed cycle wins over the watchdog
    ex_mc_start = 1;
    next_cycle();
    for (int k = 1; k <= 7; k++) next_cycle();
    mc_done = 1;
    @(negedge clk);
    vectors++; if ({mc_abort, flush_id_ex, pc_write} !== 3'b001) begin
      errors++; $display("FAIL to_done_wins got {abort,flush_id_ex,pc}=%b want 001", {mc_abort, flush_id_ex, pc_write});
    end
    next_cycle();
    clear_inputs();
    reset = 1;
    next_cycle();
    reset = 0;
    @(negedge clk);
    vectors++; if (mc_timeout !== 1'b0) begin errors++; $display("FAIL to_cleared got %b want 0", mc_timeout); end
    $display("test_timeout done");
    next_cycle();
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_taken = 1; ex_mc_start = 1;
    ex_memread = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    @(negedge clk);
    vectors++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin
      errors++; $display("FAIL br_flush got %b want 111", {flush_if_id, flush_id_ex, flush_ex_mem});
    end
    vectors++; if ({pc_write, id_ex_bubble, mc_abort} !== 3'b101) begin
      errors++; $display("FAIL br_ctrl got {pc,bubble,abort}=%b want 101", {pc_write, id_ex_bubble, mc_abort});
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    vectors++; if ({pc_write, ex_mem_bubble, flush_id_ex} !== 3'b100) begin
      errors++; $display("FAIL br_stay_run got %b want 100", {pc_write, ex_mem_bubble, flush_id_ex});
    end
    next_cycle();
    branch_taken = 1;
    @(negedge clk);
    vectors++; if ({flush_ex_mem, mc_abort} !== 2'b10) begin errors++; $display("FAIL br_plain got {flush,abort}=%b want 10", {flush_ex_mem, mc_abort}); end
    $display("test_branch done");
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    ex_mc_start = 1;
    next_cycle();
    next_cycle();
    reset = 1;
    @(negedge clk);
    vectors++; if ({pc_write, ex_mem_bubble, mc_abort} !== 3'b100) begin
      errors++; $display("FAIL rmw_during got {pc,bub,abort}=%b want 100", {pc_write, ex_mem_bubble, mc_abort});
    end
    next_cycle();
    reset = 0; ex_mc_start = 0;
    @(negedge clk);
    vectors++; if ({pc_write, ex_mem_bubble, mc_abort} !== 3'b100) begin
      errors++; $display("FAIL rmw_after got {pc,bub,abort}=%b want 100", {pc_write, ex_mem_bubble, mc_abort});
    end
    $display("test_reset_mid_wait done");
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_timeout();
    test_branch();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
